// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage FSM encoding, instruction size.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    SQUASH = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

  localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from imem, hands each
// fetched instruction plus its next-PC to the IF/ID latch, and applies
// redirects, halt and squashing of stale in-flight fetches.
//
// Handshake with IF/ID: fetch_valid is the producer's valid and !stall is the
// consumer's ready. A word moves into IF/ID on a rising CLK edge exactly when
// fetch_valid & !stall; while fetch_valid is high and stall is high, the
// presented word is held stable (in ibuf) until that edge occurs.
// Handshake with imem: iREN/imemaddr form a request that stays stable until
// ihit; only halt and reset abandon it.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ihit,
  input  logic [31:0]  imemload,
  output logic         iREN,
  output logic [31:0]  imemaddr,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         halt,
  output logic         fetch_valid,
  output logic [31:0]  fetch_instr,
  output logic [31:0]  fetch_npc,
  output fetch_state_t dbg_state
);

  word_t        pc, pc_n;
  word_t        ibuf, ibuf_n;
  word_t        pend_pc, pend_pc_n;
  fetch_state_t state, state_n;

  // State registers, asynchronously reset to the boot PC in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc      <= PC_INIT;
      state   <= IDLE;
      ibuf    <= '0;
      pend_pc <= '0;
    end else begin
      pc      <= pc_n;
      state   <= state_n;
      ibuf    <= ibuf_n;
      pend_pc <= pend_pc_n;
    end
  end

  // Next-state and output logic; halt outranks redirect, which outranks ihit/stall.
  always_comb begin
    pc_n        = pc;
    state_n     = state;
    ibuf_n      = ibuf;
    pend_pc_n   = pend_pc;
    iREN        = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;

    case (state)
      IDLE: begin
        state_n = halt ? HALTED : FETCH;
      end

      FETCH: begin
        iREN = 1'b1;
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          // A hit this cycle is for the wrong path: drop it and refetch at target.
          if (ihit) begin
            pc_n = redirect_pc;
          end else begin
            pend_pc_n = redirect_pc;
            state_n   = SQUASH;
          end
        end else if (ihit) begin
          fetch_valid = 1'b1;
          fetch_instr = imemload;
          if (!stall) begin
            pc_n = pc + WORD_BYTES;
          end else begin
            ibuf_n  = imemload;
            state_n = HOLD;
          end
        end
      end

      HOLD: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else begin
          fetch_valid = 1'b1;
          fetch_instr = ibuf;
          if (!stall) begin
            pc_n    = pc + WORD_BYTES;
            state_n = FETCH;
          end
        end
      end

      SQUASH: begin
        // Keep the stale request on the bus until imem answers it, then discard.
        iREN = 1'b1;
        if (halt) begin
          state_n = HALTED;
        end else begin
          if (redirect) begin
            pend_pc_n = redirect_pc;
          end
          if (ihit) begin
            pc_n    = redirect ? redirect_pc : pend_pc;
            state_n = FETCH;
          end
        end
      end

      HALTED: begin
        state_n = HALTED;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign imemaddr  = pc;
  assign fetch_npc = pc + WORD_BYTES;
  assign dbg_state = state;

endmodule
